// File: rtl/dram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dram_arbiter_if
// Description : Requester-side bus for the two ports of the data-RAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface dram_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          a_req;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_gnt;
  logic          a_rvalid;
  logic [DW-1:0] a_rdata;

  logic          b_req;
  logic          b_we;
  logic          b_lock;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_gnt;
  logic          b_rvalid;
  logic [DW-1:0] b_rdata;

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_gnt, a_rvalid, a_rdata,
    output b_req, b_we, b_lock, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_rdata
  );

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_gnt, a_rvalid, a_rdata,
    input  b_req, b_we, b_lock, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_rdata
  );
endinterface
`default_nettype wire

// File: rtl/dram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dram_arbiter
// Description : Shares one registered-read RAM between CPU (A) and loader (B)
//               with bounded starvation of B and a B-side burst lock.
// Revision    : 1.0 - initial release
// ============================================================================
module dram_arbiter #(
  parameter int AW     = 8,
  parameter int DW     = 8,
  parameter int STARVE = 4
) (
  input  logic          Clock,
  input  logic          Reset,
  dram_arbiter_if.slave bus,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_data,
  output logic          ram_wren,
  input  logic [DW-1:0] ram_q,
  output logic [7:0]    conflicts
);

  localparam logic [3:0] c_starve_max = 4'(STARVE);

  logic       r_lock;
  logic [3:0] r_starve;
  logic       r_rv_a;
  logic       r_rv_b;
  logic [7:0] r_conflicts;

  logic       w_a_gnt;
  logic       w_b_gnt;
  logic       w_both;

  assign w_both = bus.a_req & bus.b_req;

  always_comb begin
    w_a_gnt = 1'b0;
    w_b_gnt = 1'b0;
    if (Reset) begin
      // A held lock owns the RAM; an idle lock owner leaves the cycle unused.
      if (r_lock) begin
        w_b_gnt = bus.b_req;
      end else if (w_both) begin
        if (r_starve == c_starve_max) w_b_gnt = 1'b1;
        else                          w_a_gnt = 1'b1;
      end else begin
        w_a_gnt = bus.a_req;
        w_b_gnt = bus.b_req;
      end
    end
  end

  always_comb begin
    ram_addr = bus.a_addr;
    ram_data = bus.a_wdata;
    ram_wren = w_a_gnt & bus.a_we;
    if (w_b_gnt) begin
      ram_addr = bus.b_addr;
      ram_data = bus.b_wdata;
      ram_wren = bus.b_we;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_lock      <= 1'b0;
      r_starve    <= 4'd0;
      r_rv_a      <= 1'b0;
      r_rv_b      <= 1'b0;
      r_conflicts <= 8'd0;
    end else begin
      r_rv_a <= w_a_gnt & ~bus.a_we;
      r_rv_b <= w_b_gnt & ~bus.b_we;

      if (w_b_gnt || !bus.b_req)
        r_starve <= 4'd0;
      else if (w_a_gnt && (r_starve != c_starve_max))
        r_starve <= r_starve + 4'd1;

      if (w_b_gnt)
        r_lock <= bus.b_lock;
      else if (!bus.b_req)
        r_lock <= 1'b0;

      if (w_both && (r_conflicts != 8'hFF))
        r_conflicts <= r_conflicts + 8'd1;
    end
  end

  assign bus.a_gnt    = w_a_gnt;
  assign bus.b_gnt    = w_b_gnt;
  assign bus.a_rvalid = r_rv_a;
  assign bus.b_rvalid = r_rv_b;
  assign bus.a_rdata  = ram_q;
  assign bus.b_rdata  = ram_q;
  assign conflicts    = r_conflicts;

endmodule
`default_nettype wire

// File: tb/tb_dram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dram_arbiter
// Description : Self-checking bench: directed vector table, corner sequences
//               and constrained-random traffic against a rule-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dram_arbiter;

  localparam int STARVE = 4;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic [7:0] ram_addr;
  logic [7:0] ram_data;
  logic       ram_wren;
  logic [7:0] ram_q;
  logic [7:0] conflicts;

  dram_arbiter_if #(.AW(8), .DW(8)) bus ();

  dram_arbiter #(.AW(8), .DW(8), .STARVE(STARVE)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .bus       (bus),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .ram_wren  (ram_wren),
    .ram_q     (ram_q),
    .conflicts (conflicts)
  );

  always #5 Clock = ~Clock;

  // Registered-read single-port RAM the arbiter drives
  logic [7:0] ram_mem [256] = '{default: 8'h00};
  always @(posedge Clock) begin
    if (ram_wren) ram_mem[ram_addr] <= ram_data;
    ram_q <= ram_mem[ram_addr];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: rule-level view of the arbitration and storage
  logic [7:0] ref_mem [256] = '{default: 8'h00};
  int   m_lock    = 0;
  int   m_a_run   = 0;   // A wins in a row while B waits
  int   m_conf    = 0;
  bit   m_ga, m_gb;
  bit   exp_rva   = 0;
  bit   exp_rvb   = 0;
  logic [7:0] exp_rd = 8'h00;
  bit   s_agnt, s_bgnt;

  task automatic model_grant();
    m_ga = 0;
    m_gb = 0;
    if (Reset) begin
      if (m_lock != 0)                    m_gb = bus.b_req;
      else if (bus.a_req && bus.b_req)    begin if (m_a_run >= STARVE) m_gb = 1; else m_ga = 1; end
      else                                begin m_ga = bus.a_req; m_gb = bus.b_req; end
    end
  endtask

  task automatic model_advance();
    if (!Reset) begin
      m_lock = 0; m_a_run = 0; m_conf = 0; exp_rva = 0; exp_rvb = 0;
    end else begin
      if (bus.a_req && bus.b_req) m_conf = (m_conf < 255) ? m_conf + 1 : 255;
      if (m_gb || !bus.b_req)     m_a_run = 0;
      else if (m_ga)              m_a_run = (m_a_run < STARVE) ? m_a_run + 1 : STARVE;
      if (m_gb)                   m_lock = bus.b_lock ? 1 : 0;
      else if (!bus.b_req)        m_lock = 0;
      exp_rva = m_ga && !bus.a_we;
      exp_rvb = m_gb && !bus.b_we;
      if (m_ga) begin
        exp_rd = ref_mem[bus.a_addr];
        if (bus.a_we) ref_mem[bus.a_addr] = bus.a_wdata;
      end
      if (m_gb) begin
        exp_rd = ref_mem[bus.b_addr];
        if (bus.b_we) ref_mem[bus.b_addr] = bus.b_wdata;
      end
    end
  endtask

  // One clock: grants checked at negedge, registered results after the edge.
  task automatic run_cycle(input bit drop_rst);
    @(negedge Clock);
    model_grant();
    s_agnt = bus.a_gnt;
    s_bgnt = bus.b_gnt;
    check("a_gnt", bus.a_gnt, m_ga);
    check("b_gnt", bus.b_gnt, m_gb);
    check("ram_wren", ram_wren, (m_ga && bus.a_we) || (m_gb && bus.b_we));
    if (Reset) begin
      check("ram_addr", ram_addr, m_gb ? bus.b_addr : bus.a_addr);
      if (m_gb && bus.b_we)      check("ram_data_b", ram_data, bus.b_wdata);
      else if (m_ga && bus.a_we) check("ram_data_a", ram_data, bus.a_wdata);
    end
    if (drop_rst) begin
      Reset = 1'b0;
      #1;
      model_grant();
    end
    model_advance();
    @(posedge Clock);
    #1;
    check("a_rvalid", bus.a_rvalid, exp_rva);
    check("b_rvalid", bus.b_rvalid, exp_rvb);
    check("conflicts", conflicts, m_conf);
    if (exp_rva) check("a_rdata", bus.a_rdata, exp_rd);
    if (exp_rvb) check("b_rdata", bus.b_rdata, exp_rd);
  endtask

  typedef struct {
    logic       rst_n;
    logic       a_req, a_we;
    logic [7:0] a_addr, a_wdata;
    logic       b_req, b_we, b_lock;
    logic [7:0] b_addr, b_wdata;
    logic       e_agnt, e_bgnt, e_wren, e_rva, e_rvb;
    logic [7:0] e_rdata;
  } vec_t;

  vec_t vecs [15];

  initial begin
    bit a_pend, b_pend;

    bus.a_req = 0; bus.a_we = 0; bus.a_addr = 0; bus.a_wdata = 0;
    bus.b_req = 0; bus.b_we = 0; bus.b_lock = 0; bus.b_addr = 0; bus.b_wdata = 0;

    //          rst a_rq a_we a_ad   a_wd   b_rq b_we lck b_ad   b_wd   | agnt bgnt wren rva rvb rdata
    vecs[0]  = '{0, 1, 0, 8'h00, 8'h00, 1, 0, 0, 8'h20, 8'h00, 0, 0, 0, 0, 0, 8'h00};
    vecs[1]  = '{0, 1, 0, 8'h00, 8'h00, 1, 0, 0, 8'h20, 8'h00, 0, 0, 0, 0, 0, 8'h00};
    vecs[2]  = '{1, 1, 1, 8'h10, 8'h5A, 1, 0, 0, 8'h20, 8'h00, 1, 0, 1, 0, 0, 8'h00};
    vecs[3]  = '{1, 1, 0, 8'h10, 8'h00, 1, 0, 0, 8'h20, 8'h00, 1, 0, 0, 1, 0, 8'h5A};
    vecs[4]  = '{1, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h20, 8'h00, 0, 1, 0, 0, 1, 8'h00};
    vecs[5]  = '{1, 0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h10, 8'h00, 0, 1, 0, 0, 1, 8'h5A};
    vecs[6]  = '{1, 1, 0, 8'h11, 8'h00, 1, 0, 1, 8'h10, 8'h00, 0, 1, 0, 0, 1, 8'h5A};
    vecs[7]  = '{1, 1, 0, 8'h11, 8'h00, 1, 0, 1, 8'h10, 8'h00, 0, 1, 0, 0, 1, 8'h5A};
    vecs[8]  = '{1, 1, 0, 8'h11, 8'h00, 1, 0, 0, 8'h10, 8'h00, 0, 1, 0, 0, 1, 8'h5A};
    vecs[9]  = '{1, 1, 0, 8'h11, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 1, 0, 8'h00};
    vecs[10] = '{1, 0, 0, 8'h00, 8'h00, 1, 1, 1, 8'h30, 8'h77, 0, 1, 1, 0, 0, 8'h00};
    vecs[11] = '{1, 1, 0, 8'h30, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00};
    vecs[12] = '{1, 1, 0, 8'h30, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 1, 0, 8'h77};
    vecs[13] = '{1, 1, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 1, 0, 8'h5A};
    vecs[14] = '{0, 1, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00};

    #1;
    for (int i = 0; i < 15; i++) begin
      Reset      = vecs[i].rst_n;
      bus.a_req  = vecs[i].a_req;  bus.a_we   = vecs[i].a_we;
      bus.a_addr = vecs[i].a_addr; bus.a_wdata = vecs[i].a_wdata;
      bus.b_req  = vecs[i].b_req;  bus.b_we   = vecs[i].b_we;  bus.b_lock = vecs[i].b_lock;
      bus.b_addr = vecs[i].b_addr; bus.b_wdata = vecs[i].b_wdata;
      run_cycle(1'b0);
      check($sformatf("vec%0d_agnt", i), s_agnt, vecs[i].e_agnt);
      check($sformatf("vec%0d_bgnt", i), s_bgnt, vecs[i].e_bgnt);
      check($sformatf("vec%0d_rva", i), bus.a_rvalid, vecs[i].e_rva);
      check($sformatf("vec%0d_rvb", i), bus.b_rvalid, vecs[i].e_rvb);
      if (vecs[i].e_rva || vecs[i].e_rvb)
        check($sformatf("vec%0d_rdata", i), bus.a_rdata, vecs[i].e_rdata);
    end
    check("vec_wren_row10", 32'(ram_mem[8'h30]), 32'h77);

    // Read granted, then reset lands on the very edge that would return it
    Reset = 1'b1;
    bus.a_req = 1; bus.a_we = 0; bus.a_addr = 8'h10;
    bus.b_req = 0;
    run_cycle(1'b1);
    check("midrst_gnt", s_agnt, 1'b1);
    check("midrst_rvalid", bus.a_rvalid, 1'b0);

    // Continuous contention: A x STARVE then B, conflicts saturating
    Reset = 1'b0;
    run_cycle(1'b0);
    Reset = 1'b1;
    bus.a_req = 1; bus.a_we = 0; bus.a_addr = 8'h01;
    bus.b_req = 1; bus.b_we = 0; bus.b_lock = 0; bus.b_addr = 8'h02;
    for (int i = 0; i < 300; i++) begin
      run_cycle(1'b0);
      check("starve_b", s_bgnt, (i % 5) == 4);
      check("starve_a", s_agnt, (i % 5) != 4);
    end
    check("conflicts_sat", conflicts, 8'd255);

    // Random traffic; each requester holds its request until accepted
    a_pend = 0;
    b_pend = 0;
    for (int i = 0; i < 2000; i++) begin
      if (!a_pend && $urandom_range(3) != 0) begin
        a_pend = 1;
        bus.a_we    = 1'($urandom_range(1));
        bus.a_addr  = 8'($urandom_range(15));
        bus.a_wdata = 8'($urandom);
      end
      if (!b_pend && $urandom_range(2) != 0) begin
        b_pend = 1;
        bus.b_we    = 1'($urandom_range(1));
        bus.b_lock  = ($urandom_range(2) == 0);
        bus.b_addr  = 8'($urandom_range(15));
        bus.b_wdata = 8'($urandom);
      end
      bus.a_req = a_pend;
      bus.b_req = b_pend;
      Reset = ($urandom_range(149) != 0);
      run_cycle(1'b0);
      if (s_agnt && bus.a_req) a_pend = 0;
      if (s_bgnt && bus.b_req) b_pend = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dram_arbiter.md
# dram_arbiter

Two-requester arbiter that shares the single-port 256x8 data RAM (negedge-free, registered-read LPM RAM on `Clock`) between the CPU load/store path (port A) and a debug/DMA loader (port B). Issues at most one RAM access per cycle, returns read data with fixed one-cycle latency, and enforces a bounded-starvation rule plus a B-side burst lock. Sits between the CPU datapath's `ra_*` nets and the RAM instance; the CPU stalls on `a_gnt`=0.

## Interface
- `AW`, 8, RAM address width
- `DW`, 8, RAM data width
- `STARVE`, 4, max consecutive A grants while B is waiting (1..15)

- `Clock`  in  1  system clock, rising edge
- `Reset`  in  1  synchronous, active-low reset (sampled on rising `Clock`)
- `a_req`  in  1  CPU requests an access this cycle
- `a_we`  in  1  1 = write, 0 = read
- `a_addr`  in  AW  CPU address
- `a_wdata`  in  DW  CPU write data
- `a_gnt`  out  1  CPU access accepted this cycle (combinational)
- `a_rvalid`  out  1  read data for A valid (registered)
- `a_rdata`  out  DW  read data for A
- `b_req`, `b_we`, `b_addr`, `b_wdata`  in  1/1/AW/DW  same meaning for B
- `b_lock`  in  1  B holds the RAM after this grant
- `b_gnt`  out  1  B access accepted this cycle (combinational)
- `b_rvalid`  out  1  read data for B valid (registered)
- `b_rdata`  out  DW  read data for B
- `ram_addr`  out  AW  to RAM address
- `ram_data`  out  DW  to RAM write data
- `ram_wren`  out  1  to RAM write enable
- `ram_q`  in  DW  RAM registered read data
- `conflicts`  out  8  saturating count of cycles where both requested

## Operation
- State: `lock_q` (1b), `starve_q` (4b), `rv_a`, `rv_b`, `conflicts` (8b).
- Grant decision, in priority order (only when `Reset`=1):
  - `lock_q`=1 and `b_req`=1 -> B.
  - `lock_q`=1 and `b_req`=0 -> nobody; lock drops at next edge.
  - both request, `starve_q`==`STARVE` -> B.
  - both request otherwise -> A.
  - single requester -> that requester.
- Access is accepted iff `x_req`=1 and `x_gnt`=1 in the same cycle; requester holds signals stable until accepted.
- RAM mux: winner's addr/wdata drive `ram_addr`/`ram_data`; `ram_wren` = granted & winner's `we`. No grant: `ram_addr`=A's addr, `ram_wren`=0.
- `starve_q`: +1 (saturate at `STARVE`) when A granted and `b_req`=1; cleared when B granted or `b_req`=0.
- `lock_q`: set when B granted with `b_lock`=1; cleared when B granted with `b_lock`=0, or `b_req`=0.
- `conflicts`: +1 each cycle `a_req`&`b_req`, saturates at 255.
- `a_rdata` = `b_rdata` = `ram_q`; only the matching `rvalid` qualifies it.

## Timing
- Reset (`Reset`=0 at an edge): `lock_q`=0, `starve_q`=0, `a_rvalid`=`b_rvalid`=0, `conflicts`=0. While `Reset`=0: `a_gnt`=`b_gnt`=0, `ram_wren`=0.
- Read accepted in cycle N -> `x_rvalid`=1 for exactly cycle N+1, data = RAM at that address.
- Write in N, read same address in N+1 -> returns new data.
- Back-to-back accepted reads from one port -> `rvalid` high on consecutive cycles.
- Reset asserted in the cycle after a read grant: `rvalid` forced 0, the read is dropped.
- Lock has no timeout; B is trusted to release.
- Write accepted -> no `rvalid`.

## Test plan
- Reset=0 for 2 cycles with both requesting -> both gnt 0, ram_wren 0, all registered outputs 0; after release A granted first.
- A writes 0x5A to 0x10 then reads 0x10 -> a_gnt both cycles, a_rvalid one cycle after read with a_rdata=0x5A.
- A and B requesting continuously, STARVE=4 -> grant pattern A,A,A,A,B repeating; conflicts counts every cycle, saturates at 255.
- B reads with b_lock=1 for 3 accesses while A requests -> B granted 3 cycles, a_gnt 0; b_lock=0 on 4th -> A granted next cycle.
- B locked then drops b_req -> no grant that cycle, A granted next cycle.
- A read granted, Reset=0 next edge -> a_rvalid stays 0.
